// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter that shares one OBI slave port among MASTERS requesters.
// An in-order ID FIFO routes responses; define OBI_ARB_LOCK_EN for master locking.
module obi_rr_arbiter #(
    parameter int  MASTERS     = 2,
    parameter int  OUTSTANDING = 2,
    localparam int IDW         = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [MASTERS-1:0]    master_req_i,
    output logic [MASTERS-1:0]    master_gnt_o,
    output logic [MASTERS-1:0]    master_rvalid_o,
    input  logic [MASTERS-1:0]    master_we_i,
    input  logic [MASTERS*4-1:0]  master_be_i,
    input  logic [MASTERS*32-1:0] master_addr_i,
    input  logic [MASTERS*32-1:0] master_wdata_i,
`ifdef OBI_ARB_LOCK_EN
    input  logic [MASTERS-1:0]    master_lock_i,
`endif
    output logic [31:0]           master_rdata_o,
    output logic                  slave_req_o,
    input  logic                  slave_gnt_i,
    input  logic                  slave_rvalid_i,
    output logic                  slave_we_o,
    output logic [3:0]            slave_be_o,
    output logic [31:0]           slave_addr_o,
    output logic [31:0]           slave_wdata_o,
    input  logic [31:0]           slave_rdata_i,
    output logic                  busy_o,
    output logic                  rsp_err_o
);

    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] winner;
    logic           win_valid;
    logic [IDW-1:0] fifo_q [OUTSTANDING];
    logic [PW-1:0]  wr_q, rd_q;
    logic [CW-1:0]  count_q;
    logic           err_q;
    logic           fifo_full, fifo_empty;
    logic           handshake, pop, ptr_frozen;

`ifdef OBI_ARB_LOCK_EN
    logic           locked_q;
    logic [IDW-1:0] lock_id_q;
    assign ptr_frozen = locked_q;
`else
    assign ptr_frozen = 1'b0;
`endif

    function automatic logic [PW-1:0] slot_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fifo_full  = (count_q == CW'(OUTSTANDING));
    assign fifo_empty = (count_q == '0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        logic [IDW:0] cand;
        winner    = ptr_q;
        win_valid = 1'b0;
        cand      = '0;
        for (int i = 0; i < MASTERS; i++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(MASTERS)) cand = cand - (IDW+1)'(MASTERS);
            if (!win_valid && master_req_i[cand[IDW-1:0]]) begin
                win_valid = 1'b1;
                winner    = cand[IDW-1:0];
            end
        end
`ifdef OBI_ARB_LOCK_EN
        // A locked owner is the only candidate; others wait even if it is idle.
        if (locked_q) begin
            winner    = lock_id_q;
            win_valid = master_req_i[lock_id_q];
        end
`endif
    end

    // Full blocks new requests even when a pop lands in the same cycle.
    assign slave_req_o    = win_valid & ~fifo_full & ~rst_i;
    assign handshake      = slave_req_o & slave_gnt_i;
    assign pop            = slave_rvalid_i & ~fifo_empty & ~rst_i;
    assign master_rdata_o = slave_rdata_i;
    assign busy_o         = (count_q != '0);
    assign rsp_err_o      = err_q;

    always_comb begin
        slave_we_o      = 1'b0;
        slave_be_o      = '0;
        slave_addr_o    = '0;
        slave_wdata_o   = '0;
        master_gnt_o    = '0;
        master_rvalid_o = '0;
        for (int k = 0; k < MASTERS; k++) begin
            if (win_valid && winner == IDW'(k)) begin
                slave_we_o    = master_we_i[k];
                slave_be_o    = master_be_i[4*k +: 4];
                slave_addr_o  = master_addr_i[32*k +: 32];
                slave_wdata_o = master_wdata_i[32*k +: 32];
            end
            if (handshake && winner == IDW'(k)) master_gnt_o[k] = 1'b1;
            if (pop && fifo_q[rd_q] == IDW'(k)) master_rvalid_o[k] = 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (handshake) fifo_q[wr_q] <= winner;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
`ifdef OBI_ARB_LOCK_EN
            locked_q  <= 1'b0;
            lock_id_q <= '0;
`endif
        end else begin
            if (handshake) begin
                wr_q <= slot_inc(wr_q);
                if (!ptr_frozen)
                    ptr_q <= (winner == IDW'(MASTERS - 1)) ? '0 : winner + IDW'(1);
            end
            if (pop) rd_q <= slot_inc(rd_q);
            unique case ({handshake, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (slave_rvalid_i && fifo_empty) err_q <= 1'b1;
`ifdef OBI_ARB_LOCK_EN
            if (handshake) begin
                if (locked_q) begin
                    if (!master_lock_i[lock_id_q]) locked_q <= 1'b0;
                end else if (master_lock_i[winner]) begin
                    locked_q  <= 1'b1;
                    lock_id_q <= winner;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Self-checking bench for obi_rr_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model (lock scenario only when OBI_ARB_LOCK_EN is defined).
module tb_obi_rr_arbiter;

    localparam int M = 2;
    localparam int O = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [M-1:0]  req, we, gnt_o, rvalid_o;
    logic [4*M-1:0]  be;
    logic [32*M-1:0] addr, wdata;
    logic [31:0]   rdata_o, s_addr, s_wdata, s_rdata;
    logic [3:0]    s_be;
    logic          s_req, s_gnt, s_rvalid, s_we, busy, err;
`ifdef OBI_ARB_LOCK_EN
    logic [M-1:0]  lock;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: priority pointer, queue of outstanding master IDs, sticky error.
    int   m_ptr = 0;
    int   m_q[$];
    bit   m_err = 1'b0;
    int   exp_win;
    logic exp_req, exp_we, exp_busy, exp_err;
    logic [M-1:0] exp_gnt, exp_rvalid;
    logic [3:0]   exp_be;
    logic [31:0]  exp_addr, exp_wdata;

    always #5 clk = ~clk;

    obi_rr_arbiter #(.MASTERS(M), .OUTSTANDING(O)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .master_req_i    (req),
        .master_gnt_o    (gnt_o),
        .master_rvalid_o (rvalid_o),
        .master_we_i     (we),
        .master_be_i     (be),
        .master_addr_i   (addr),
        .master_wdata_i  (wdata),
`ifdef OBI_ARB_LOCK_EN
        .master_lock_i   (lock),
`endif
        .master_rdata_o  (rdata_o),
        .slave_req_o     (s_req),
        .slave_gnt_i     (s_gnt),
        .slave_rvalid_i  (s_rvalid),
        .slave_we_o      (s_we),
        .slave_be_o      (s_be),
        .slave_addr_o    (s_addr),
        .slave_wdata_o   (s_wdata),
        .slave_rdata_i   (s_rdata),
        .busy_o          (busy),
        .rsp_err_o       (err)
    );

    function void model_eval();
        exp_win = -1;
        for (int i = 0; i < M; i++) begin
            int k;
            k = (m_ptr + i) % M;
            if (exp_win < 0 && req[k]) exp_win = k;
        end
        exp_req    = (exp_win >= 0) && (m_q.size() < O) && !rst;
        exp_gnt    = '0;
        exp_rvalid = '0;
        if (exp_req && s_gnt) exp_gnt[exp_win] = 1'b1;
        if (s_rvalid && m_q.size() > 0 && !rst) exp_rvalid[m_q[0]] = 1'b1;
        exp_we = 1'b0; exp_be = '0; exp_addr = '0; exp_wdata = '0;
        if (exp_win >= 0) begin
            exp_we    = we[exp_win];
            exp_be    = be[4*exp_win +: 4];
            exp_addr  = addr[32*exp_win +: 32];
            exp_wdata = wdata[32*exp_win +: 32];
        end
        exp_busy = (m_q.size() != 0);
        exp_err  = m_err;
    endfunction

    function void model_update();
        if (rst) begin
            m_ptr = 0;
            m_q.delete();
            m_err = 1'b0;
        end else begin
            if (s_rvalid && m_q.size() == 0) m_err = 1'b1;
            if (exp_rvalid != '0) void'(m_q.pop_front());
            if (exp_gnt != '0) begin
                m_q.push_back(exp_win);
                m_ptr = (exp_win + 1) % M;
            end
        end
    endfunction

    task settle();
        @(negedge clk);
        model_eval();
    endtask

    task advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task idle_inputs();
        req = '0; we = '0; be = '0; addr = '0; wdata = '0;
        s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
`ifdef OBI_ARB_LOCK_EN
        lock = '0;
`endif
    endtask

    task do_reset();
        rst = 1'b1;
        idle_inputs();
        settle();
        advance();
        rst = 1'b0;
    endtask

    task test_reset();
        rst = 1'b1;
        idle_inputs();
        req = 2'b11; s_gnt = 1'b1; s_rvalid = 1'b1;
        settle();
        n_total++; if (s_req !== 1'b0) $display("FAIL reset_sreq: got %b want 0", s_req); else n_pass++;
        n_total++; if (gnt_o !== 2'b00) $display("FAIL reset_gnt: got %b want 00", gnt_o); else n_pass++;
        n_total++; if (rvalid_o !== 2'b00) $display("FAIL reset_rvalid: got %b want 00", rvalid_o); else n_pass++;
        advance();
        rst = 1'b0;
        idle_inputs();
        settle();
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        advance();
    endtask

    task test_single_master();
        do_reset();
        req = 2'b10; s_gnt = 1'b1;
        addr[63:32] = 32'h2000_0010;
        settle();
        n_total++; if (gnt_o !== 2'b10) $display("FAIL single_gnt: got %b want 10", gnt_o); else n_pass++;
        n_total++; if (s_addr !== 32'h2000_0010) $display("FAIL single_addr: got %h want 20000010", s_addr); else n_pass++;
        advance();
        req = 2'b00; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
        settle();
        n_total++; if (rvalid_o !== 2'b10) $display("FAIL single_rvalid: got %b want 10", rvalid_o); else n_pass++;
        n_total++; if (rdata_o !== 32'hDEAD_BEEF) $display("FAIL single_rdata: got %h want deadbeef", rdata_o); else n_pass++;
        advance();
        idle_inputs();
    endtask

    task test_fairness();
        do_reset();
        req = 2'b11; s_gnt = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [1:0] want_g, want_r;
            want_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            want_r = (i % 2 == 0) ? 2'b10 : 2'b01;
            s_rvalid = (i > 0);
            s_rdata  = 32'(i);
            settle();
            n_total++; if (gnt_o !== want_g) $display("FAIL fair_gnt[%0d]: got %b want %b", i, gnt_o, want_g); else n_pass++;
            if (i > 0) begin
                n_total++; if (rvalid_o !== want_r) $display("FAIL fair_rvalid[%0d]: got %b want %b", i, rvalid_o, want_r); else n_pass++;
            end
            advance();
        end
        req = 2'b00; s_rvalid = 1'b1;
        settle();
        advance();
        idle_inputs();
    endtask

    task test_backpressure();
        do_reset();
        req = 2'b11; s_gnt = 1'b1;
        settle();
        n_total++; if (gnt_o !== 2'b01) $display("FAIL bp_gnt0: got %b want 01", gnt_o); else n_pass++;
        advance();
        settle();
        n_total++; if (gnt_o !== 2'b10) $display("FAIL bp_gnt1: got %b want 10", gnt_o); else n_pass++;
        advance();
        settle();
        n_total++; if (s_req !== 1'b0) $display("FAIL bp_full_sreq: got %b want 0", s_req); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL bp_busy: got %b want 1", busy); else n_pass++;
        advance();
        s_rvalid = 1'b1; s_rdata = 32'hA5;
        settle();
        n_total++; if (rvalid_o !== 2'b01) $display("FAIL bp_pop_rvalid: got %b want 01", rvalid_o); else n_pass++;
        n_total++; if (s_req !== 1'b0) $display("FAIL bp_nobypass: got %b want 0", s_req); else n_pass++;
        advance();
        s_rvalid = 1'b0;
        settle();
        n_total++; if (s_req !== 1'b1) $display("FAIL bp_reassert: got %b want 1", s_req); else n_pass++;
        n_total++; if (gnt_o !== 2'b01) $display("FAIL bp_regrant: got %b want 01", gnt_o); else n_pass++;
        advance();
        req = 2'b00; s_rvalid = 1'b1;
        settle();
        n_total++; if (rvalid_o !== 2'b10) $display("FAIL bp_drain1: got %b want 10", rvalid_o); else n_pass++;
        advance();
        settle();
        n_total++; if (rvalid_o !== 2'b01) $display("FAIL bp_drain2: got %b want 01", rvalid_o); else n_pass++;
        advance();
        idle_inputs();
    endtask

    task test_ordering();
        do_reset();
        req = 2'b01; s_gnt = 1'b1;
        settle();
        n_total++; if (gnt_o !== 2'b01) $display("FAIL ord_gnt0: got %b want 01", gnt_o); else n_pass++;
        advance();
        req = 2'b10; s_rvalid = 1'b1; s_rdata = 32'h11;
        settle();
        n_total++; if (gnt_o !== 2'b10) $display("FAIL ord_gnt1: got %b want 10", gnt_o); else n_pass++;
        n_total++; if (rvalid_o !== 2'b01) $display("FAIL ord_rvalid0: got %b want 01", rvalid_o); else n_pass++;
        n_total++; if (rdata_o !== 32'h11) $display("FAIL ord_rdata0: got %h want 11", rdata_o); else n_pass++;
        advance();
        req = 2'b00; s_rdata = 32'h22;
        settle();
        n_total++; if (rvalid_o !== 2'b10) $display("FAIL ord_rvalid1: got %b want 10", rvalid_o); else n_pass++;
        n_total++; if (rdata_o !== 32'h22) $display("FAIL ord_rdata1: got %h want 22", rdata_o); else n_pass++;
        advance();
        idle_inputs();
    endtask

    task test_error_reset();
        do_reset();
        s_rvalid = 1'b1;
        settle();
        n_total++; if (rvalid_o !== 2'b00) $display("FAIL err_rvalid_empty: got %b want 00", rvalid_o); else n_pass++;
        advance();
        s_rvalid = 1'b0; req = 2'b01; s_gnt = 1'b1;
        settle();
        n_total++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else n_pass++;
        n_total++; if (gnt_o !== 2'b01) $display("FAIL err_gnt: got %b want 01", gnt_o); else n_pass++;
        advance();
        req = 2'b00; rst = 1'b1;
        settle();
        n_total++; if (busy !== 1'b1) $display("FAIL err_busy_pre: got %b want 1", busy); else n_pass++;
        advance();
        rst = 1'b0; req = 2'b11; s_rvalid = 1'b1;
        settle();
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
        n_total++; if (gnt_o !== 2'b01) $display("FAIL rst_ptr: got %b want 01", gnt_o); else n_pass++;
        n_total++; if (rvalid_o !== 2'b00) $display("FAIL late_rvalid: got %b want 00", rvalid_o); else n_pass++;
        advance();
        req = 2'b00; s_rvalid = 1'b0;
        settle();
        n_total++; if (err !== 1'b1) $display("FAIL late_err: got %b want 1", err); else n_pass++;
        advance();
        do_reset();
    endtask

    task test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            req      = M'($urandom);
            we       = M'($urandom);
            be       = (4*M)'($urandom);
            addr     = {$urandom, $urandom};
            wdata    = {$urandom, $urandom};
            s_gnt    = ($urandom_range(3, 0) != 0);
            s_rdata  = $urandom;
            s_rvalid = (m_q.size() > 0) ? $urandom_range(1, 0) == 1 : $urandom_range(39, 0) == 0;
            settle();
            n_total++; if (gnt_o !== exp_gnt) $display("FAIL rnd_gnt[%0d]: got %b want %b", c, gnt_o, exp_gnt); else n_pass++;
            n_total++; if (rvalid_o !== exp_rvalid) $display("FAIL rnd_rvalid[%0d]: got %b want %b", c, rvalid_o, exp_rvalid); else n_pass++;
            n_total++; if (s_req !== exp_req) $display("FAIL rnd_sreq[%0d]: got %b want %b", c, s_req, exp_req); else n_pass++;
            n_total++; if ({s_we, s_be, s_addr, s_wdata} !== {exp_we, exp_be, exp_addr, exp_wdata})
                $display("FAIL rnd_payload[%0d]: got %b/%h/%h/%h want %b/%h/%h/%h", c,
                         s_we, s_be, s_addr, s_wdata, exp_we, exp_be, exp_addr, exp_wdata);
            else n_pass++;
            n_total++; if (rdata_o !== s_rdata) $display("FAIL rnd_rdata[%0d]: got %h want %h", c, rdata_o, s_rdata); else n_pass++;
            n_total++; if (busy !== exp_busy) $display("FAIL rnd_busy[%0d]: got %b want %b", c, busy, exp_busy); else n_pass++;
            n_total++; if (err !== exp_err) $display("FAIL rnd_err[%0d]: got %b want %b", c, err, exp_err); else n_pass++;
            advance();
        end
        idle_inputs();
    endtask

`ifdef OBI_ARB_LOCK_EN
    task test_lock();
        do_reset();
        req = 2'b10; lock = 2'b10; s_gnt = 1'b1;
        settle();
        n_total++; if (gnt_o !== 2'b10) $display("FAIL lock_acquire: got %b want 10", gnt_o); else n_pass++;
        advance();
        req = 2'b11; s_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_total++; if (gnt_o !== 2'b10) $display("FAIL lock_hold[%0d]: got %b want 10", i, gnt_o); else n_pass++;
            advance();
        end
        lock = 2'b00;
        settle();
        n_total++; if (gnt_o !== 2'b10) $display("FAIL lock_release: got %b want 10", gnt_o); else n_pass++;
        advance();
        settle();
        n_total++; if (gnt_o !== 2'b01) $display("FAIL lock_after: got %b want 01", gnt_o); else n_pass++;
        advance();
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_single_master();
        test_fairness();
        test_backpressure();
        test_ordering();
        test_error_reset();
`ifdef OBI_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
- Shares one OBI slave port between MASTERS OBI requesters, e.g. core data port and JTAG host contending for RAM, or several masters feeding a single-ported peripheral.
- Round-robin grant; the arbiter owns the slave-side request/grant handshake.
- Tracks outstanding transactions in an in-order ID FIFO so each rvalid/rdata returns to the master that issued the request.
- Sits between the masters and one slave, or in front of a slave port of obi_interconnect.

Parameters:
- MASTERS, 2, number of requesters (2..8).
- OUTSTANDING, 2, max granted-but-unanswered transactions (power of 2, 1..8).
- IDW, $clog2(MASTERS) (min 1), width of the stored master ID; derived, not overridden.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- master_req_i  in  MASTERS  request per master
- master_gnt_o  out  MASTERS  grant per master; one-hot or zero
- master_rvalid_o  out  MASTERS  response valid per master; one-hot or zero
- master_we_i  in  MASTERS  write enable per master
- master_be_i  in  MASTERS*4  byte enables, master k at [4k+3:4k]
- master_addr_i  in  MASTERS*32  address, master k at [32k+31:32k]
- master_wdata_i  in  MASTERS*32  write data per master
- master_rdata_o  out  32  read data; same value to all masters, qualified by master_rvalid_o
- slave_req_o  out  1  request to slave
- slave_gnt_i  in  1  grant from slave
- slave_rvalid_i  in  1  response valid from slave
- slave_we_o / slave_be_o / slave_addr_o / slave_wdata_o  out  1/4/32/32  muxed from the winning master
- slave_rdata_i  in  32  read data from slave
- busy_o  out  1  one or more transactions outstanding
- rsp_err_o  out  1  sticky: slave_rvalid_i seen while no transaction was outstanding

Behaviour:
- Clock and reset: one clock clk_i; reset rst_i is synchronous and active-high, sampled on the rising edge of clk_i.
- Reset state:
  - Priority pointer = 0, ID FIFO empty, rsp_err_o = 0, busy_o = 0.
  - While rst_i is high, slave_req_o, master_gnt_o and master_rvalid_o are forced to 0.
- Arbitration (combinational, same cycle):
  - Winner = first requesting master found scanning from ptr upward, wrapping modulo MASTERS.
  - slave_req_o = any master_req_i AND NOT fifo_full.
  - Slave-side payload is muxed from the winner. When no master requests, the payload is 0.
  - master_gnt_o[winner] = slave_req_o AND slave_gnt_i. Zero request-to-grant latency is added.
- Handshake (slave_req_o & slave_gnt_i) at a clock edge:
  - Push winner ID into the FIFO.
  - ptr <= winner+1 mod MASTERS.
  - If there is no handshake, ptr holds. A stalled winner keeps priority until granted.
- Response:
  - slave_rvalid_i pops the FIFO head.
  - master_rvalid_o[head] = slave_rvalid_i in the same cycle; master_rdata_o = slave_rdata_i.
  - Responses are in order. The slave guarantees rvalid no earlier than 1 cycle after its gnt.
- FIFO boundaries:
  - Full: slave_req_o = 0, even if a pop occurs in the same cycle (no bypass; keeps the path short).
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
  - rvalid while empty: no pop, all master_rvalid_o = 0, rsp_err_o <= 1 until reset.
  - Pointers wrap modulo OUTSTANDING.
- busy_o = (count != 0), registered from the FIFO count.
- Reset mid-operation:
  - The FIFO is flushed.
  - Late slave responses to pre-reset transactions set rsp_err_o and are dropped. The system resets slaves together with the arbiter.

Optional Feature:
- Macro: OBI_ARB_LOCK_EN.
- Enabled:
  - Adds input master_lock_i [MASTERS].
  - After a handshake by master k with master_lock_i[k] = 1, the arbiter is locked to k: only k can win and ptr is frozen.
  - The lock releases on the first handshake by k with master_lock_i[k] = 0, or on reset.
  - While locked and k is idle, slave_req_o = 0.
- Disabled: port absent; pure round-robin.

Test Plan:
- Single master: with MASTERS=2, slave gnt=1, and rvalid 1 cycle later, only master 1 requests addr 0x2000_0010. Expect gnt[1] in the same cycle, slave_addr_o=0x2000_0010, then rvalid[1] with rdata 0xDEADBEEF; gnt[0] and rvalid[0] stay 0.
- Fairness: both masters request continuously for 8 cycles with slave gnt=1. Expect grants alternating 0,1,0,1,…; ptr=0 after reset gives master 0 first.
- Backpressure: with OUTSTANDING=2 and rvalid withheld, two grants occur, then slave_req_o=0 and busy_o=1. Raise rvalid for 1 cycle: rvalid goes to the first master, and slave_req_o reasserts in the following cycle.
- Ordering: master 0 is granted at cycle t and master 1 at t+1; the slave returns rdata 0x11 then 0x22. Expect rvalid[0] with 0x11, then rvalid[1] with 0x22.
- Error and reset: rvalid arrives with the FIFO empty -> rsp_err_o=1 and no master_rvalid_o. Assert rst_i with 1 transaction outstanding -> next cycle busy_o=0, rsp_err_o=0, ptr=0.
- Lock (OBI_ARB_LOCK_EN): master 1 locks and both masters request -> only master 1 is granted for 3 handshakes. Master 1 drops lock on the 4th -> master 0 wins next.
